// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the ID->EX hazard controller: instruction ID codes,
//   forwarding-select encodings, FSM state type and the instruction decode
//   helper used to classify register usage.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   localparam int unsigned InstIdW = 4;

   // Decoded instruction IDs presented by ID; any other code is "unknown"
   localparam logic [InstIdW-1:0] ID_NOP  = 4'd0;
   localparam logic [InstIdW-1:0] ID_ADDI = 4'd1;
   localparam logic [InstIdW-1:0] ID_ADD  = 4'd2;
   localparam logic [InstIdW-1:0] ID_LUI  = 4'd3;
   localparam logic [InstIdW-1:0] ID_JAL  = 4'd4;
   localparam logic [InstIdW-1:0] ID_LW   = 4'd5;
   localparam logic [InstIdW-1:0] ID_SW   = 4'd6;
   localparam logic [InstIdW-1:0] ID_BNE  = 4'd7;

   // Operand source selects for the regfile read mux
   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   typedef enum logic {
      StRun   = 1'b0,
      StFlush = 1'b1
   } hz_state_e;

   typedef struct packed {
      logic writes_rd;
      logic uses_rs1;
      logic uses_rs2;
      logic is_load;
   } dec_t;

   // Unknown IDs decode to "touches no registers"
   function automatic dec_t decode(input logic [InstIdW-1:0] id);
      dec_t d;
      d = '0;
      case (id)
         ID_ADDI: begin d.writes_rd = 1'b1; d.uses_rs1 = 1'b1; end
         ID_ADD:  begin d.writes_rd = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         ID_LUI:  d.writes_rd = 1'b1;
         ID_JAL:  d.writes_rd = 1'b1;
         ID_LW:   begin d.writes_rd = 1'b1; d.uses_rs1 = 1'b1; d.is_load = 1'b1; end
         ID_SW:   begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         ID_BNE:  begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// -----------------------------------------------------------------------------
// pipe_fwd_unit
//   Combinational operand hazard check for both source operands of the ID
//   instruction against the EX and MEM destination trackers.
// Ports
//   i_id_vld        ID holds a valid instruction
//   i_rs1/i_rs2     source register indices
//   i_use_rs1/2     operand is actually read by the instruction
//   i_ex_rd/wr/ld   destination info of the instruction now in EX
//   i_mem_rd/wr     destination info of the instruction now in MEM
//   o_fwd_rs*_sel   FWD_RF / FWD_EX / FWD_MEM per operand
//   o_load_use      a used operand needs the result of the load in EX
// -----------------------------------------------------------------------------
module pipe_fwd_unit
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic       i_id_vld,
   input  logic [4:0] i_rs1,
   input  logic [4:0] i_rs2,
   input  logic       i_use_rs1,
   input  logic       i_use_rs2,
   input  logic [4:0] i_ex_rd,
   input  logic       i_ex_wr,
   input  logic       i_ex_ld,
   input  logic [4:0] i_mem_rd,
   input  logic       i_mem_wr,
   output logic [1:0] o_fwd_rs1_sel,
   output logic [1:0] o_fwd_rs2_sel,
   output logic       o_load_use
);

   logic w_rs1_live;
   logic w_rs2_live;
   logic w_rs1_ex;
   logic w_rs2_ex;
   logic w_rs1_mem;
   logic w_rs2_mem;

   // x0 is hard-wired zero, so it never participates in any hazard
   assign w_rs1_live = i_use_rs1 && (i_rs1 != 5'd0);
   assign w_rs2_live = i_use_rs2 && (i_rs2 != 5'd0);

   // A load in EX has no result yet; that case is the load-use stall instead
   assign w_rs1_ex  = w_rs1_live && i_ex_wr && !i_ex_ld && (i_rs1 == i_ex_rd);
   assign w_rs2_ex  = w_rs2_live && i_ex_wr && !i_ex_ld && (i_rs2 == i_ex_rd);
   assign w_rs1_mem = w_rs1_live && i_mem_wr && (i_rs1 == i_mem_rd);
   assign w_rs2_mem = w_rs2_live && i_mem_wr && (i_rs2 == i_mem_rd);

   always_comb begin
      o_fwd_rs1_sel = FWD_RF;
      o_fwd_rs2_sel = FWD_RF;
      if (w_rs1_ex) begin
         o_fwd_rs1_sel = FWD_EX;
      end else if (w_rs1_mem) begin
         o_fwd_rs1_sel = FWD_MEM;
      end
      if (w_rs2_ex) begin
         o_fwd_rs2_sel = FWD_EX;
      end else if (w_rs2_mem) begin
         o_fwd_rs2_sel = FWD_MEM;
      end
   end

   assign o_load_use = i_id_vld && i_ex_ld &&
                       ((w_rs1_live && (i_rs1 == i_ex_rd)) ||
                        (w_rs2_live && (i_rs2 == i_ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Issue sequencer between the IF/ID register and Execute. Inserts one bubble
//   on a load-use hazard and kills FLUSH_CYCLES issue slots after a taken
//   branch; drives operand forwarding selects and stall/flush perf counters.
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_id_vld              ID holds a decoded instruction
//   i_id_inst_id          decoded instruction ID
//   i_id_rs1/rs2/rd       register indices of the ID instruction
//   i_ex_jmp_vld          taken branch resolved by Execute
//   o_ex_inst_vld         issue ID->EX this cycle
//   o_stall_if            hold PC and IF/ID
//   o_flush_if            redirect PC, kill IF/ID
//   o_fwd_rs1/rs2_sel     operand source selects
//   o_stall_cnt           load-use bubbles inserted (wraps)
//   o_flush_cnt           branch-shadow slots killed (wraps)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_id_vld,
   input  logic [InstIdW-1:0] i_id_inst_id,
   input  logic [4:0]         i_id_rs1,
   input  logic [4:0]         i_id_rs2,
   input  logic [4:0]         i_id_rd,
   input  logic               i_ex_jmp_vld,
   output logic               o_ex_inst_vld,
   output logic               o_stall_if,
   output logic               o_flush_if,
   output logic [1:0]         o_fwd_rs1_sel,
   output logic [1:0]         o_fwd_rs2_sel,
   output logic [CNT_W-1:0]   o_stall_cnt,
   output logic [CNT_W-1:0]   o_flush_cnt
);

   localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FcW-1:0] FcLoad = FcW'(FLUSH_CYCLES - 1);

   hz_state_e        r_state, w_state_d;
   logic [FcW-1:0]   r_fc, w_fc_d;
   logic [4:0]       r_ex_rd, r_mem_rd;
   logic             r_ex_wr, r_ex_ld, r_mem_wr;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   dec_t             w_dec;
   logic             w_load_use;
   logic             w_stall_inc;
   logic             w_flush_inc;

   assign w_dec = decode(i_id_inst_id);

   pipe_fwd_unit u_fwd (
      .i_id_vld      (i_id_vld),
      .i_rs1         (i_id_rs1),
      .i_rs2         (i_id_rs2),
      .i_use_rs1     (w_dec.uses_rs1),
      .i_use_rs2     (w_dec.uses_rs2),
      .i_ex_rd       (r_ex_rd),
      .i_ex_wr       (r_ex_wr),
      .i_ex_ld       (r_ex_ld),
      .i_mem_rd      (r_mem_rd),
      .i_mem_wr      (r_mem_wr),
      .o_fwd_rs1_sel (o_fwd_rs1_sel),
      .o_fwd_rs2_sel (o_fwd_rs2_sel),
      .o_load_use    (w_load_use)
   );

   always_comb begin
      w_state_d     = r_state;
      w_fc_d        = r_fc;
      o_ex_inst_vld = 1'b0;
      o_stall_if    = 1'b0;
      o_flush_if    = 1'b0;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;
      unique case (r_state)
         StRun: begin
            // A taken branch outranks a simultaneous load-use hazard
            if (i_ex_jmp_vld) begin
               o_flush_if  = 1'b1;
               w_flush_inc = 1'b1;
               w_fc_d      = FcLoad;
               if (FcLoad != '0) begin
                  w_state_d = StFlush;
               end
            end else begin
               o_ex_inst_vld = i_id_vld && !w_load_use;
               o_stall_if    = w_load_use;
               w_stall_inc   = w_load_use;
            end
         end
         StFlush: begin
            // Jumps cannot resolve here since nothing was issued
            w_flush_inc = 1'b1;
            w_fc_d      = r_fc - FcW'(1);
            if (r_fc == FcW'(1)) begin
               w_state_d = StRun;
            end
         end
         default: begin
            w_state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StRun;
         r_fc        <= '0;
         r_ex_rd     <= '0;
         r_ex_wr     <= 1'b0;
         r_ex_ld     <= 1'b0;
         r_mem_rd    <= '0;
         r_mem_wr    <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state  <= w_state_d;
         r_fc     <= w_fc_d;
         // Track only what actually entered EX; writes to x0 are dropped
         r_ex_rd  <= o_ex_inst_vld ? i_id_rd : 5'd0;
         r_ex_wr  <= o_ex_inst_vld && w_dec.writes_rd && (i_id_rd != 5'd0);
         r_ex_ld  <= o_ex_inst_vld && w_dec.is_load;
         r_mem_rd <= r_ex_rd;
         r_mem_wr <= r_ex_wr;
         if (w_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush_inc) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;

endmodule
